// File: rtl/homo_result_fifo.sv
// -----------------------------------------------------------------------------
// homo_result_fifo
//   Downstream sink of the homomorphic evaluation stage. Every in_data word
//   qualified by in_we is captured into a first-word-fall-through FIFO. The
//   RISC-V side drains it through a valid/ready read port. Fill level, a sticky
//   overflow flag and a saturating dropped-word counter let software detect
//   lost shares.
//
// Ports
//   CLK       in   system clock, all state on the rising edge
//   RST       in   asynchronous, active-low reset
//   in_data   in   result word from the homomorphic stage
//   in_we     in   word valid strobe, one word per high cycle
//   clr       in   synchronous flush: empty FIFO, clear overflow and drop_cnt
//   rd_data   out  head-of-FIFO word, 0 while rd_valid=0
//   rd_valid  out  FIFO non-empty
//   rd_ready  in   consumer accepts the head word this cycle
//   level     out  number of stored words, 0..DEPTH
//   full      out  level == DEPTH
//   overflow  out  sticky: a word was dropped since last reset/clr
//   drop_cnt  out  words dropped since last reset/clr, saturates at all-ones
// -----------------------------------------------------------------------------
module homo_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DROP_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_we,
  input  logic              clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [AW:0]       level,
  output logic              full,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_cnt_q;

  logic push;
  logic pop;
  logic drop;

  // Status comes from registered state only, so in_we never reaches an output
  // combinationally.
  assign rd_valid = (level_q != '0);
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop  = rd_valid & rd_ready;
  assign push = in_we & (~full | pop);
  assign drop = in_we & full & ~pop;

  // First-word-fall-through: the head is read straight out of the array.
  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array has no reset branch; stale entries are unreachable
  // because rd_valid gates the read, and leaving it unreset lets it map to RAM.
  always_ff @(posedge CLK) begin
    if (push && !clr) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr) begin
      // Flush wins over any same-cycle push, pop or drop.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_q <= drop_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_homo_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_homo_result_fifo
//   Self-checking bench for homo_result_fifo: a directed vector table, hand
//   sequences for the multi-cycle corners, and a randomized run compared
//   against a queue-based reference model. The drop counter is instantiated
//   narrow so that its saturation point is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_homo_result_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int DROP_W = 4;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_we = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [AW:0]       level;
  logic              full;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  homo_result_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .DROP_W(DROP_W)
  ) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_we(in_we), .clr(clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .level(level), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: contents as an ordered queue plus the two drop counters.
  logic [DATA_W-1:0] mq[$];
  logic              m_ovf = 1'b0;
  int                m_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " level"},    32'(level),    32'(mq.size()));
    check({tag, " rd_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
    check({tag, " full"},     32'(full),     32'(mq.size() == DEPTH));
    check({tag, " rd_data"},  rd_data,       (mq.size() != 0) ? mq[0] : 32'h0);
    check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  // One clock: drive inputs, advance the model on the same rules, sample #1
  // after the edge and compare every output.
  task automatic step(input logic we, input logic [DATA_W-1:0] d,
                      input logic rdy, input logic c, input string tag);
    bit m_full, m_pop, m_push;
    in_we = we; in_data = d; rd_ready = rdy; clr = c;
    m_full = (mq.size() == DEPTH);
    m_pop  = (mq.size() != 0) && rdy;
    m_push = we && (!m_full || m_pop);
    if (c) begin
      model_reset();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(d);
      else if (we) begin
        m_ovf = 1'b1;
        if (m_drop < DROP_MAX) m_drop++;
      end
    end
    @(posedge CLK);
    #1;
    in_we = 1'b0; rd_ready = 1'b0; clr = 1'b0;
    compare_model(tag);
  endtask

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] d;
    logic              rdy;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    int                exp_level;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Basic in-order capture and drain; expectations are post-edge values.
    vecs[0] = '{1'b1, 32'h800, 1'b0, 1'b1, 32'h800, 1};
    vecs[1] = '{1'b1, 32'h802, 1'b0, 1'b1, 32'h800, 2};
    vecs[2] = '{1'b1, 32'h200, 1'b0, 1'b1, 32'h800, 3};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h802, 2};
    vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1};
    vecs[5] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0};
    vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0};

    // Reset state.
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    check("reset level",    32'(level),    32'h0);
    check("reset full",     32'(full),     32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset drop_cnt", 32'(drop_cnt), 32'h0);
    check("reset rd_data",  rd_data,       32'h0);
    model_reset();

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].we, vecs[i].d, vecs[i].rdy, 1'b0, "vec");
      check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d rd_data", i),  rd_data,       vecs[i].exp_data);
      check($sformatf("vec%0d level", i),    32'(level),    32'(vecs[i].exp_level));
    end

    // 20 pushes into a 16-deep FIFO: four words dropped, first 16 kept.
    for (int i = 0; i < 20; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0, "fill");
    check("fill full",     32'(full),     32'h1);
    check("fill level",    32'(level),    32'd16);
    check("fill overflow", 32'(overflow), 32'h1);
    check("fill drop_cnt", 32'(drop_cnt), 32'd4);
    for (int i = 0; i < 16; i++) begin
      check("drain order", rd_data, 32'(i));
      step(1'b0, '0, 1'b1, 1'b0, "drain");
    end
    check("drain empty", 32'(rd_valid), 32'h0);

    // Full FIFO with simultaneous push and pop across three pointer wraps.
    for (int i = 0; i < 16; i++) step(1'b1, 32'd100 + 32'(i), 1'b0, 1'b0, "refill");
    for (int k = 0; k < 48; k++) begin
      check("wrap head", rd_data, (k < 16) ? 32'd100 + 32'(k) : 32'd200 + 32'(k - 16));
      step(1'b1, 32'd200 + 32'(k), 1'b1, 1'b0, "wrap");
      check("wrap level", 32'(level), 32'd16);
      if (k == 4) check("wrap drop_cnt", 32'(drop_cnt), 32'd4);
    end

    // Level 5 with overflow set, then clr together with a push.
    step(1'b0, '0, 1'b0, 1'b1, "clr0");
    for (int i = 0; i < 17; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, "lv5 fill");
    for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 1'b0, "lv5 drain");
    check("lv5 level",    32'(level),    32'd5);
    check("lv5 overflow", 32'(overflow), 32'h1);
    step(1'b1, 32'hdead, 1'b0, 1'b1, "clr");
    check("clr level",    32'(level),    32'h0);
    check("clr rd_valid", 32'(rd_valid), 32'h0);
    check("clr overflow", 32'(overflow), 32'h0);
    check("clr drop_cnt", 32'(drop_cnt), 32'h0);
    step(1'b0, '0, 1'b0, 1'b0, "clr after");
    check("clr word absent", 32'(rd_valid), 32'h0);

    // Drop counter saturation.
    for (int i = 0; i < DEPTH + DROP_MAX + 5; i++) step(1'b1, 32'(i), 1'b0, 1'b0, "sat");
    check("sat drop_cnt", 32'(drop_cnt), 32'(DROP_MAX));
    step(1'b0, '0, 1'b0, 1'b1, "sat clr");

    // Async reset mid-drain at level 7.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, "rst fill");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "rst drain");
    check("rst pre level", 32'(level), 32'd7);
    rd_ready = 1'b1;
    #2 RST = 1'b0;
    #1;
    check("async rd_valid", 32'(rd_valid), 32'h0);
    check("async level",    32'(level),    32'h0);
    check("async full",     32'(full),     32'h0);
    check("async rd_data",  rd_data,       32'h0);
    model_reset();
    rd_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    step(1'b1, 32'h4a0, 1'b0, 1'b0, "post rst");
    check("post rst rd_data",  rd_data,       32'h4a0);
    check("post rst rd_valid", 32'(rd_valid), 32'h1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 63) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
